window_line_buffer: RTL and testbench
=====================================

# window_line_buffer

Streaming 3x3 window generator for the bilateral filter datapath. Accepts one raster-order pixel per valid cycle and stores the two previous image lines in internal line buffers. It emits a complete 3x3 neighbourhood, plus the centre-pixel coordinates, for every pixel position whose window lies fully inside the frame. It sits directly upstream of the filter-weight pipeline; that pipeline's delay-matching shift stages carry `win_row`/`win_col` alongside the computed result.

## Interface

Parameters:
- `DATA_WIDTH` (default 8): pixel width in bits.
- `IMG_WIDTH` (default 640): pixels per line; must be ≥3.
- `IMG_HEIGHT` (default 480): lines per frame; must be ≥3.
- `COL_W` = `$clog2(IMG_WIDTH)`: column index width (localparam).
- `ROW_W` = `$clog2(IMG_HEIGHT)`: row index width (localparam).

Ports:
- `clk` input, 1: single clock, all logic on rising edge.
- `rst_n` input, 1: reset, asynchronous assert, active-low.
- `in_valid` input, 1: `in_data` valid this cycle; no backpressure.
- `in_sof` input, 1: start of frame; qualified by `in_valid`, marks pixel (0,0).
- `in_data` input, `DATA_WIDTH`: pixel value.
- `win_valid` output, 1: `win_data`/`win_row`/`win_col` valid this cycle.
- `win_data` output, `9*DATA_WIDTH`: window; tap (r,c) at `[(r*3+c)*DATA_WIDTH +: DATA_WIDTH]`. r=0 is the top (oldest) row, c=0 is the leftmost column.
- `win_row` output, `ROW_W`: row of the centre pixel (tap 1,1).
- `win_col` output, `COL_W`: column of the centre pixel.
- `frame_done` output, 1: one-cycle pulse with the last window of a frame.
- `sof_err` output, 1: one-cycle pulse when `in_sof` arrives mid-frame.

## Operation

- States:
  - IDLE: reset state. Pixels without `in_sof` are dropped. `in_valid & in_sof` accepts the pixel as (0,0) and moves to ACTIVE.
  - ACTIVE: every `in_valid` pixel is accepted at (row,col). `col` wraps at `IMG_WIDTH-1` to 0 and increments `row`.
  - After the pixel at (`IMG_HEIGHT-1`,`IMG_WIDTH-1`) is accepted, the state returns to IDLE.
- Counters `row`/`col` hold the position of the next pixel. Cycles with `in_valid=0` change no state.
- Two line buffers, `lb0` and `lb1`, each `IMG_WIDTH` deep, `DATA_WIDTH` wide, indexed by `col`. `lb1` holds row-1; `lb0` holds row-2.
- On each accepted pixel p at column c:
  - New column vector = {`lb0[c]`, `lb1[c]`, p} as rows 0, 1, 2. This is read-before-write.
  - `lb0[c]` ← `lb1[c]`; `lb1[c]` ← p.
  - Window columns shift left (c0 ← c1, c1 ← c2) and the new vector enters c2.
- Window is valid when the accepted pixel has row ≥2 and col ≥2. The centre is at (row-1, col-1). Windows per frame = (`IMG_WIDTH`-2)(`IMG_HEIGHT`-2).
- No padding: border pixels produce no window. Stale data that enters the taps at col 0/1 is never flagged valid.
- `in_sof` with `in_valid` while ACTIVE:
  - Pulse `sof_err`.
  - Restart the frame with this pixel as (0,0); the state stays ACTIVE.
  - Old line-buffer contents are not cleared; they are overwritten before any window uses them.
- `in_sof` without `in_valid` is ignored.
- Line-buffer contents are not reset. Window taps, counters, state and all outputs are reset.

## Timing

- Reset values: `win_valid`=0, `win_data`=0, `win_row`=0, `win_col`=0, `frame_done`=0, `sof_err`=0, state=IDLE, `row`=`col`=0.
- Latency: pixel accepted in cycle N → its window (if valid) appears in cycle N+1 with `win_valid`=1 for exactly one cycle.
- Outputs are registered. `win_data`/`win_row`/`win_col` hold their values when `win_valid`=0.
- `frame_done` asserts in the same cycle as `win_valid` for centre (`IMG_HEIGHT`-2, `IMG_WIDTH`-2).
- `sof_err` asserts in cycle N+1 for an offending `in_sof` accepted in cycle N.
- Full throughput: one window per cycle with `in_valid` held high. Gaps in `in_valid` insert matching gaps in `win_valid`.
- Back-to-back frames: `in_sof` in the cycle immediately after the last pixel is accepted normally, with no idle cycle required and no `sof_err`.
- `rst_n` low mid-frame clears `win_valid` and counters immediately (asynchronous). After release, the block waits in IDLE for `in_sof`.

## Test plan

All scenarios use `IMG_WIDTH`=5, `IMG_HEIGHT`=4, `DATA_WIDTH`=8, pixel value = row*16+col.

- **Continuous frame:** `in_valid` held high for 20 pixels.
  - Exactly 6 `win_valid` pulses.
  - First pulse one cycle after pixel (2,2): `win_row`=1, `win_col`=1, tap(0,0)=0x00, tap(1,1)=0x11, tap(2,2)=0x22.
  - Last pulse: centre (2,3), tap(2,2)=0x34, coincident with `frame_done`.
- **Random `in_valid` gaps** (~50% duty): identical 6 windows with identical contents; each window appears one cycle after its completing pixel.
- **Pre-frame data:** 3 pixels without `in_sof` while IDLE, then a normal frame → the 3 pixels are ignored and the windows match the continuous-frame scenario.
- **Mid-frame SOF:** `in_sof` on pixel 8 → `sof_err` pulse one cycle later. The following 20 pixels form a clean frame with 6 correct windows; stale line data never appears in a valid window.
- **Back-to-back frames** with pixel values +0x80 in frame 2 → 12 windows total, no `sof_err`, 2 `frame_done` pulses; frame-2 first window tap(1,1)=0x91.
- **Async reset** asserted after pixel (2,3): `win_valid`=0 immediately. A subsequent full frame produces exactly 6 correct windows.

Source files
------------

// File: rtl/window_line_buffer.sv
// window_line_buffer: streaming 3x3 window generator with two internal line buffers
module window_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    localparam int COL_W = $clog2(IMG_WIDTH),
    localparam int ROW_W = $clog2(IMG_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    win_valid,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic [ROW_W-1:0]        win_row,
    output logic [COL_W-1:0]        win_col,
    output logic                    frame_done,
    output logic                    sof_err
);
    typedef enum logic {S_IDLE, S_ACTIVE} state_t;
    state_t                  r_state;
    logic [ROW_W-1:0]        r_row;
    logic [COL_W-1:0]        r_col;
    logic [DATA_WIDTH-1:0]   r_lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]   r_lb1 [IMG_WIDTH];
    logic [3*DATA_WIDTH-1:0] r_c1;
    logic [3*DATA_WIDTH-1:0] r_c2;
    logic                    w_accept;
    logic                    w_sof_err;
    logic                    w_last_col;
    logic                    w_last_row;
    logic                    w_win_ok;
    logic [ROW_W-1:0]        w_row;
    logic [COL_W-1:0]        w_col;
    logic [3*DATA_WIDTH-1:0] w_vec;
    logic [9*DATA_WIDTH-1:0] w_win;
    // An SOF pixel always lands at (0,0), even when it restarts a running frame
    always_comb begin
        w_accept   = in_valid & (in_sof | (r_state == S_ACTIVE));
        w_sof_err  = in_valid & in_sof & (r_state == S_ACTIVE);
        w_col      = in_sof ? '0 : r_col;
        w_row      = in_sof ? '0 : r_row;
        w_last_col = (w_col == COL_W'(IMG_WIDTH - 1));
        w_last_row = (w_row == ROW_W'(IMG_HEIGHT - 1));
        w_win_ok   = w_accept & (w_row >= ROW_W'(2)) & (w_col >= COL_W'(2));
        w_vec      = {in_data, r_lb1[w_col], r_lb0[w_col]};
    end
    // Window columns: two registered vectors on the left, the incoming vector on the right
    always_comb begin
        w_win = '0;
        for (int r = 0; r < 3; r++) begin
            w_win[(3*r)*DATA_WIDTH   +: DATA_WIDTH] = r_c1[r*DATA_WIDTH +: DATA_WIDTH];
            w_win[(3*r+1)*DATA_WIDTH +: DATA_WIDTH] = r_c2[r*DATA_WIDTH +: DATA_WIDTH];
            w_win[(3*r+2)*DATA_WIDTH +: DATA_WIDTH] = w_vec[r*DATA_WIDTH +: DATA_WIDTH];
        end
    end
    // Line buffers age one row per accepted pixel; contents are never reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[w_col] <= r_lb1[w_col];
            r_lb1[w_col] <= in_data;
        end
    end
    // Frame FSM, position counters, window taps and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_c1       <= '0;
            r_c2       <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_col   <= w_last_col ? '0 : w_col + 1'b1;
                r_row   <= w_last_col ? (w_last_row ? '0 : w_row + 1'b1) : w_row;
                r_state <= (w_last_col & w_last_row) ? S_IDLE : S_ACTIVE;
                r_c1    <= r_c2;
                r_c2    <= w_vec;
            end
            if (w_win_ok) begin
                win_data <= w_win;
                win_row  <= w_row - 1'b1;
                win_col  <= w_col - 1'b1;
            end
            win_valid  <= w_win_ok;
            frame_done <= w_accept & w_last_col & w_last_row;
            sof_err    <= w_sof_err;
        end
    end
endmodule

// File: tb/tb_window_line_buffer.sv
// tb_window_line_buffer: directed and randomized checks of the 3x3 window generator
module tb_window_line_buffer;
    localparam int W = 5;
    localparam int H = 4;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_data;
    logic        win_valid;
    logic [71:0] win_data;
    logic [1:0]  win_row;
    logic [2:0]  win_col;
    logic        frame_done;
    logic        sof_err;
    int checks = 0;
    int errors = 0;
    int n_win, n_fd, n_sof;
    logic [7:0]  img [H][W];
    bit          m_active;
    int          m_row, m_col;
    logic        exp_valid, exp_fd, exp_sof;
    logic [71:0] exp_data;
    logic [1:0]  exp_row;
    logic [2:0]  exp_col;

    window_line_buffer #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .win_valid(win_valid), .win_data(win_data), .win_row(win_row), .win_col(win_col),
        .frame_done(frame_done), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_row = 0;
        m_col = 0;
        exp_valid = 1'b0;
        exp_fd = 1'b0;
        exp_sof = 1'b0;
        exp_data = '0;
        exp_row = '0;
        exp_col = '0;
    endtask

    // One input cycle: model the frame from the image array, then compare after the edge
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sof = s;
        in_data = d;
        exp_valid = 1'b0;
        exp_fd = 1'b0;
        exp_sof = 1'b0;
        if (v && (s || m_active)) begin
            if (s) begin
                exp_sof = m_active;
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = d;
            if (m_row >= 2 && m_col >= 2) begin
                exp_valid = 1'b1;
                exp_row = 2'(m_row - 1);
                exp_col = 3'(m_col - 1);
                exp_fd = (m_row == H - 1) && (m_col == W - 1);
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        exp_data[(r*3+c)*8 +: 8] = img[m_row-2+r][m_col-2+c];
            end
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row++;
            end
            if (m_row == H) begin
                m_row = 0;
                m_active = 1'b0;
            end else begin
                m_active = 1'b1;
            end
        end
        @(negedge clk);
        if (win_valid) n_win++;
        if (frame_done) n_fd++;
        if (sof_err) n_sof++;
        check("win_valid", 72'(win_valid), 72'(exp_valid));
        check("frame_done", 72'(frame_done), 72'(exp_fd));
        check("sof_err", 72'(sof_err), 72'(exp_sof));
        check("win_data", win_data, exp_data);
        check("win_row", 72'(win_row), 72'(exp_row));
        check("win_col", 72'(win_col), 72'(exp_col));
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom), 8'($urandom));
    endtask

    task automatic send_frame(input int base, input bit gaps, input int npix, input bit rnd);
        for (int i = 0; i < npix; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle();
            step(1'b1, i == 0, rnd ? 8'($urandom) : 8'(base + (i / W) * 16 + (i % W)));
        end
    endtask

    task automatic clear_counts();
        n_win = 0;
        n_fd = 0;
        n_sof = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_data = '0;
        model_reset();
        clear_counts();
        repeat (2) @(negedge clk);
        check("reset_valid", 72'(win_valid), 72'd0);
        check("reset_data", win_data, 72'd0);
        check("reset_row_col", 72'({win_row, win_col}), 72'd0);
        check("reset_pulses", 72'({frame_done, sof_err}), 72'd0);
        rst_n = 1'b1;
        // continuous frame
        send_frame(0, 1'b0, 20, 1'b0);
        check("cont_windows", 72'(n_win), 72'd6);
        check("cont_frame_done", 72'(n_fd), 72'd1);
        repeat (2) idle();
        // random valid gaps
        clear_counts();
        send_frame(0, 1'b1, 20, 1'b0);
        check("gap_windows", 72'(n_win), 72'd6);
        repeat (2) idle();
        // pre-frame data without sof is dropped
        clear_counts();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom));
        send_frame(0, 1'b0, 20, 1'b0);
        check("pre_windows", 72'(n_win), 72'd6);
        // mid-frame sof restarts with different values so stale lines would show
        clear_counts();
        send_frame(0, 1'b0, 8, 1'b0);
        send_frame(8'h40, 1'b0, 20, 1'b0);
        check("mid_sof_errs", 72'(n_sof), 72'd1);
        check("mid_windows", 72'(n_win), 72'd6);
        // back-to-back frames
        clear_counts();
        send_frame(0, 1'b0, 20, 1'b0);
        send_frame(8'h80, 1'b0, 20, 1'b0);
        check("b2b_windows", 72'(n_win), 72'd12);
        check("b2b_frame_done", 72'(n_fd), 72'd2);
        check("b2b_sof_errs", 72'(n_sof), 72'd0);
        // asynchronous reset after pixel (2,3)
        send_frame(0, 1'b0, 14, 1'b0);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        #1;
        check("areset_valid", 72'(win_valid), 72'd0);
        check("areset_data", win_data, 72'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        step(1'b1, 1'b0, 8'h55);
        send_frame(0, 1'b0, 20, 1'b0);
        check("post_reset_windows", 72'(n_win), 72'd6);
        // random pixel values with gaps
        clear_counts();
        send_frame(0, 1'b1, 20, 1'b1);
        check("rand_windows", 72'(n_win), 72'd6);
        repeat (2) idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
